// File: rtl/rot_pkg.sv
// -----------------------------------------------------------------------------
// rot_pkg
// Shared definitions for the rotation amount finder and its rotate-by-one step.
//   WIDTH_DEF / SHW_DEF : default data width and shift-amount width
//   state_t             : search FSM states
//   ROT_LEFT / ROT_RIGHT: encoding of the direction select
// -----------------------------------------------------------------------------
package rot_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int SHW_DEF   = $clog2(WIDTH_DEF);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic ROT_LEFT  = 1'b0;
  localparam logic ROT_RIGHT = 1'b1;

endpackage

// File: rtl/rotate_step.sv
// -----------------------------------------------------------------------------
// rotate_step
// Combinational rotate of a WIDTH-bit word by exactly one position.
//   i_data : word to rotate
//   i_dir  : ROT_LEFT (0) or ROT_RIGHT (1)
//   o_data : rotated word
// -----------------------------------------------------------------------------
module rotate_step
  import rot_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_dir,
  output logic [WIDTH-1:0] o_data
);

  assign o_data = (i_dir == ROT_RIGHT) ? {i_data[0], i_data[WIDTH-1:1]}
                                       : {i_data[WIDTH-2:0], i_data[WIDTH-1]};

endmodule

// File: rtl/rotation_amount_finder.sv
// -----------------------------------------------------------------------------
// rotation_amount_finder
// Finds the smallest rotation amount that maps src_data onto tgt_data in the
// selected direction, testing one candidate amount per cycle.
//   clk, rst                  : clock, synchronous active-high reset
//   in_valid / in_ready       : request handshake (ready only while idle)
//   sel_left_or_right_rotate  : 0 = left-rotate amount, 1 = right-rotate amount
//   src_data / tgt_data       : original word / rotated word
//   out_valid / out_ready     : result handshake
//   found / shift_amt         : match flag and smallest amount (0 if no match)
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a request, in_ready high
// SEARCH | compare candidate with target, rotate candidate by one if no hit
// DONE   | result presented, held until out_ready
// -----------------------------------------------------------------------------
module rotation_amount_finder
  import rot_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sel_left_or_right_rotate,
  input  logic [WIDTH-1:0] src_data,
  input  logic [WIDTH-1:0] tgt_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             found,
  output logic [SHW-1:0]   shift_amt
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_cand;
  logic [WIDTH-1:0] r_tgt;
  logic             r_dir;
  logic [SHW-1:0]   r_k;
  logic             r_found;
  logic [SHW-1:0]   r_shift_amt;

  logic [WIDTH-1:0] w_cand_rot;
  logic             w_match;
  logic             w_last;
  logic             w_in_ready;
  logic             w_out_valid;

  rotate_step #(
    .WIDTH (WIDTH)
  ) u_rotate_step (
    .i_data (r_cand),
    .i_dir  (r_dir),
    .o_data (w_cand_rot)
  );

  assign w_match = (r_cand == r_tgt);
  // Amount WIDTH-1 is the last candidate, so k never wraps.
  assign w_last  = (r_k == SHW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          w_state_nxt = SEARCH;
        end
      end
      SEARCH: begin
        if (w_match || w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_out_valid = 1'b1;
        // Return to IDLE first; a new request waits for the next cycle.
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cand      <= '0;
      r_tgt       <= '0;
      r_dir       <= ROT_LEFT;
      r_k         <= '0;
      r_found     <= 1'b0;
      r_shift_amt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_cand <= src_data;
            r_tgt  <= tgt_data;
            r_dir  <= sel_left_or_right_rotate;
            r_k    <= '0;
          end
        end
        SEARCH: begin
          // Checking the match before advancing guarantees the smallest k wins.
          if (w_match) begin
            r_found     <= 1'b1;
            r_shift_amt <= r_k;
          end else if (w_last) begin
            r_found     <= 1'b0;
            r_shift_amt <= '0;
          end else begin
            r_cand <= w_cand_rot;
            r_k    <= r_k + SHW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign found     = r_found;
  assign shift_amt = r_shift_amt;

endmodule

// File: tb/tb_rotation_amount_finder.sv
module tb_rotation_amount_finder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        sel;
  logic [31:0] src;
  logic [31:0] tgt;
  logic        out_valid;
  logic        out_ready;
  logic        found;
  logic [4:0]  shift_amt;

  int checks = 0;
  int errors = 0;
  bit noise  = 1'b0;

  typedef struct {
    logic       found;
    logic [4:0] amt;
    int         lat;
  } exp_t;

  typedef struct {
    logic [31:0] src;
    logic [31:0] tgt;
    logic        dir;
    logic        exp_found;
    logic [4:0]  exp_amt;
    int          exp_lat;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[11];

  rotation_amount_finder dut (
    .clk                      (clk),
    .rst                      (rst),
    .in_valid                 (in_valid),
    .in_ready                 (in_ready),
    .sel_left_or_right_rotate (sel),
    .src_data                 (src),
    .tgt_data                 (tgt),
    .out_valid                (out_valid),
    .out_ready                (out_ready),
    .found                    (found),
    .shift_amt                (shift_amt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] x, input int k);
    if (k == 0) return x;
    return (x << k) | (x >> (32 - k));
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] x, input int k);
    if (k == 0) return x;
    return (x >> k) | (x << (32 - k));
  endfunction

  function automatic void model_find(input logic [31:0] s, input logic [31:0] t, input logic d,
                                     output logic f, output logic [4:0] a);
    f = 1'b0;
    a = 5'd0;
    for (int k = 31; k >= 0; k--) begin
      if (((d == 1'b0) ? rotl(s, k) : rotr(s, k)) == t) begin
        f = 1'b1;
        a = 5'(k);
      end
    end
  endfunction

  function automatic bit aperiodic(input logic [31:0] s);
    for (int k = 1; k < 32; k++) begin
      if (rotl(s, k) == s) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic do_req(input string name, input logic [31:0] s, input logic [31:0] t,
                        input logic d, input logic ef, input logic [4:0] ea, input int el,
                        output logic [4:0] got_amt);
    exp_t e;
    int   n;
    chk({name, " in_ready"}, 32'(in_ready), 32'd1);
    src      = s;
    tgt      = t;
    sel      = d;
    in_valid = 1'b1;
    e.found  = ef;
    e.amt    = ea;
    e.lat    = el;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    src      = $urandom;
    tgt      = $urandom;
    sel      = ~d;
    n        = 1;
    while (!out_valid && n < 40) begin
      if (noise) begin
        in_valid = n[0];
        src      = 32'h0;
        tgt      = 32'h0;
      end
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    chk({name, " out_valid"}, 32'(out_valid), 32'd1);
    e = sb_q.pop_front();
    chk({name, " found"}, 32'(found), 32'(e.found));
    chk({name, " shift_amt"}, 32'(shift_amt), 32'(e.amt));
    chk({name, " latency"}, 32'(n), 32'(e.lat));
    got_amt = shift_amt;
    if (out_ready) begin
      @(posedge clk);
      #1;
      chk({name, " post out_valid"}, 32'(out_valid), 32'd0);
      chk({name, " post in_ready"}, 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  amt;
    logic [4:0]  gl;
    logic [4:0]  gr;
    logic        mf;
    logic [4:0]  ma;
    logic [31:0] s;
    logic [31:0] t;
    int          k;
    int          seen;

    vecs[0]  = '{32'hA5A5A5A5, 32'h4B4B4B4B, 1'b0, 1'b1, 5'd1,  3};
    vecs[1]  = '{32'h00000001, 32'h80000000, 1'b0, 1'b1, 5'd31, 33};
    vecs[2]  = '{32'h00000001, 32'h80000000, 1'b1, 1'b1, 5'd1,  3};
    vecs[3]  = '{32'h00000001, 32'h00000003, 1'b0, 1'b0, 5'd0,  33};
    vecs[4]  = '{32'h12345678, 32'h12345678, 1'b0, 1'b1, 5'd0,  2};
    vecs[5]  = '{32'h12345678, 32'h12345678, 1'b1, 1'b1, 5'd0,  2};
    vecs[6]  = '{32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 1'b1, 5'd4,  6};
    vecs[7]  = '{32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, 1'b1, 5'd4,  6};
    vecs[8]  = '{32'hA5A5A5A5, 32'hA5A5A5A5, 1'b1, 1'b1, 5'd0,  2};
    vecs[9]  = '{32'h00000000, 32'h00000001, 1'b1, 1'b0, 5'd0,  33};
    vecs[10] = '{32'h00000003, 32'h00000006, 1'b1, 1'b1, 5'd31, 33};

    rst       = 1'b1;
    in_valid  = 1'b0;
    sel       = 1'b0;
    src       = 32'h0;
    tgt       = 32'h0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset found", 32'(found), 32'd0);
    chk("reset shift_amt", 32'(shift_amt), 32'd0);

    for (int i = 0; i < 11; i++) begin
      do_req($sformatf("vec%0d", i), vecs[i].src, vecs[i].tgt, vecs[i].dir,
             vecs[i].exp_found, vecs[i].exp_amt, vecs[i].exp_lat, amt);
    end

    // in_valid pulses while searching must not disturb the captured request
    noise = 1'b1;
    do_req("noise", 32'h00000001, 32'h00000100, 1'b0, 1'b1, 5'd8, 10, amt);
    noise = 1'b0;

    // back-pressure: result held in DONE, in_valid ignored
    out_ready = 1'b0;
    do_req("bp", 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 1'b1, 5'd4, 6, amt);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      src      = 32'h0;
      tgt      = 32'h0;
      @(posedge clk);
      #1;
      chk($sformatf("bp hold%0d out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp hold%0d found", i), 32'(found), 32'd1);
      chk($sformatf("bp hold%0d shift_amt", i), 32'(shift_amt), 32'd4);
      chk($sformatf("bp hold%0d in_ready", i), 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b1;
    src       = 32'h12345678;
    tgt       = 32'h12345678;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp release out_valid", 32'(out_valid), 32'd0);
    chk("bp release in_ready", 32'(in_ready), 32'd1);
    chk("bp release found kept", 32'(found), 32'd1);
    @(posedge clk);
    #1;
    chk("bp no accept in handshake", 32'(in_ready), 32'd1);

    // reset during SEARCH at k=5 abandons the search
    src      = 32'h00000001;
    tgt      = 32'h80000000;
    sel      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid search in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst in_ready", 32'(in_ready), 32'd1);
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst found", 32'(found), 32'd0);
    chk("midrst shift_amt", 32'(shift_amt), 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("midrst no result", 32'(seen), 32'd0);
    do_req("after rst", 32'h00000001, 32'h80000000, 1'b1, 1'b1, 5'd1, 3, amt);

    // random pairs in both directions, scored against the reference model
    for (int i = 0; i < 8; i++) begin
      s = $urandom;
      k = int'($urandom_range(0, 31));
      t = i[0] ? rotr(s, k) : rotl(s, k);
      model_find(s, t, 1'b0, mf, ma);
      do_req($sformatf("rnd%0d L", i), s, t, 1'b0, mf, ma, mf ? int'(ma) + 2 : 33, gl);
      model_find(s, t, 1'b1, mf, ma);
      do_req($sformatf("rnd%0d R", i), s, t, 1'b1, mf, ma, mf ? int'(ma) + 2 : 33, gr);
      if (aperiodic(s)) begin
        chk($sformatf("rnd%0d lr identity", i), 32'(gr), 32'((32 - int'(gl)) % 32));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
